inv_ark_mix_cols: RTL
=====================

Name: inv_ark_mix_cols

Overview:
- Inverse-round stage directly downstream of the inverse SubBytes block in the AES-128 decryption datapath.
- Takes the 128-bit state after InvSubBytes, applies AddRoundKey, then InvMixColumns unless the round is the final one.
- Iterative: processes one 32-bit column per clock to save area.
- valid/ready handshake on both sides; holds its result until the consumer accepts it.

Parameters:
- COLS, 4, columns per state; fixed for AES and checked by an elaboration assertion.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  state_in, round_key and skip_mix are valid
- in_ready  output  1  block can accept a new state
- state_in  input  128  state from InvSubBytes
- round_key  input  128  round key for this round
- skip_mix  input  1  1 = final round; AddRoundKey only, no InvMixColumns
- out_valid  output  1  state_out is valid
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  resulting state

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, reset.
- Byte order is FIPS-197. Column c occupies bits [127-32c -: 32]. Row r within that column occupies bits [127-32c-8r -: 8].
- Reset values: in_ready=1, out_valid=0, state_out=0. FSM goes to IDLE and the column counter goes to 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture state_in ^ round_key into the working register.
  - If skip_mix=1, go to DONE. Otherwise clear the column counter and go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, replace column[cnt] with InvMixColumn(column[cnt]) and increment cnt.
  - After cnt=3 is processed, go to DONE. cnt wraps to 0.
- DONE:
  - out_valid=1 and state_out = working register. state_out is stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE and drop out_valid in the next cycle.
- Latency, counted from the accepting edge to the first cycle with out_valid high:
  - skip_mix=1: 1 cycle.
  - skip_mix=0: 5 cycles.
- No new input is accepted in DONE, even when out_ready is high that cycle. The minimum issue interval is latency + 1.
- InvMixColumn uses GF(2^8) with polynomial 0x11B and coefficients {0e,0b,0d,09} in circulant form. Each output byte is the XOR of four products, all 8-bit.
- in_valid while in_ready=0 is ignored, and the inputs are not sampled.
- Reset asserted mid-operation aborts immediately. The partial state is discarded and the block returns to reset values.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- AES_INV_MIX_PARALLEL_EN defined:
  - Four inv_mix_column instances.
  - BUSY lasts exactly one cycle and transforms all columns.
  - skip_mix=0 latency is 2 cycles; skip_mix=1 latency is unchanged at 1.
- Not defined: one shared instance, muxed by cnt, with the 4-cycle BUSY described above.
- Output values are identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - the state width constant (128), column width constant (32) and COLS;
  - the FSM state enum;
  - xtime and gf_mul functions and the InvMixColumns coefficient constants.
- Sub-module inv_mix_column: combinational, 32-bit column in, 32-bit column out, implemented with the aes_pkg functions.

Test Plan:
- Mix with zero key: state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6, round_key=0, skip_mix=0, out_ready=1 -> state_out=db135345_f20a225c_01010101_c6c6c6c6. out_valid rises 5 cycles after accept (2 with AES_INV_MIX_PARALLEL_EN).
- Key path: state_in=0, round_key=8e4da1bc_9fdc589d_01010101_c6c6c6c6, skip_mix=0 -> state_out=db135345_f20a225c_01010101_c6c6c6c6.
- Final round: state_in=00112233_44556677_8899aabb_ccddeeff, round_key=00010203_04050607_08090a0b_0c0d0e0f, skip_mix=1 -> state_out=00102030_40506070_8090a0b0_c0d0e0f0 after 1 cycle.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: state_out stays stable, in_ready=0, and a second in_valid pulse is ignored.
  - Then release out_ready: out_valid falls next cycle and in_ready=1.
- Reset mid-BUSY: assert reset 2 cycles after accept -> out_valid=0, state_out=0, in_ready=1 asynchronously. The next transaction gives the correct result.
- Back-to-back: issue 3 transactions with in_valid held high and out_ready=1 -> three correct results in order, each accepted only when in_ready=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-round datapath.
// Contents:
//   - the state width (128), the column width (32) and the column count
//   - the control FSM state type
//   - GF(2^8) helpers (polynomial 0x11B): xtime, gf_mul
//   - the InvMixColumns circulant coefficients {0e,0b,0d,09}
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned COLS    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] INV_MIX_C0 = 8'h0e;
  localparam logic [7:0] INV_MIX_C1 = 8'h0b;
  localparam logic [7:0] INV_MIX_C2 = 8'h0d;
  localparam logic [7:0] INV_MIX_C3 = 8'h09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant coefficient this folds to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (a[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_ark_mix_cols_if.sv
// Handshake bus for inv_ark_mix_cols.
// Input side : in_valid, in_ready, state_in, round_key, skip_mix
// Output side: out_valid, out_ready, state_out
// Modports: slave = the round stage, master = the producer/consumer side.
interface inv_ark_mix_cols_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state_in;
  logic [STATE_W-1:0] round_key;
  logic               skip_mix;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;

  modport slave (
    input  in_valid, state_in, round_key, skip_mix, out_ready,
    output in_ready, out_valid, state_out
  );

  modport master (
    output in_valid, state_in, round_key, skip_mix, out_ready,
    input  in_ready, out_valid, state_out
  );

endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumn of one 32-bit column (FIPS-197 byte order,
// row 0 in the top byte).
// Ports:
//   col_in  [31:0]  column before the transform
//   col_out [31:0]  column after the transform
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out[31:24] = gf_mul(INV_MIX_C0, a0) ^ gf_mul(INV_MIX_C1, a1)
                        ^ gf_mul(INV_MIX_C2, a2) ^ gf_mul(INV_MIX_C3, a3);
  assign col_out[23:16] = gf_mul(INV_MIX_C3, a0) ^ gf_mul(INV_MIX_C0, a1)
                        ^ gf_mul(INV_MIX_C1, a2) ^ gf_mul(INV_MIX_C2, a3);
  assign col_out[15:8]  = gf_mul(INV_MIX_C2, a0) ^ gf_mul(INV_MIX_C3, a1)
                        ^ gf_mul(INV_MIX_C0, a2) ^ gf_mul(INV_MIX_C1, a3);
  assign col_out[7:0]   = gf_mul(INV_MIX_C1, a0) ^ gf_mul(INV_MIX_C2, a1)
                        ^ gf_mul(INV_MIX_C3, a2) ^ gf_mul(INV_MIX_C0, a3);

endmodule

// File: rtl/inv_ark_mix_cols.sv
// AES-128 inverse-round stage after InvSubBytes: AddRoundKey followed by
// InvMixColumns (skipped in the final round).
// Default build: one shared inv_mix_column, one column per clock (4-cycle BUSY).
// Macro AES_INV_MIX_PARALLEL_EN: four instances, all columns in one BUSY cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    inv_ark_mix_cols_if.slave (valid/ready in, valid/ready out, 128-bit data)
// Parameter COLS: columns per state, must be 4.
module inv_ark_mix_cols #(
  parameter int unsigned COLS = 4
) (
  input  logic                clk,
  input  logic                reset,
  inv_ark_mix_cols_if.slave   bus
);
  import aes_pkg::*;

  if (COLS != 4) begin : g_cols_check
    $error("inv_ark_mix_cols: COLS must be 4 for AES");
  end

  state_t             state;
  logic [STATE_W-1:0] work;

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.state_out = (state == DONE) ? work : '0;
  end

`ifdef AES_INV_MIX_PARALLEL_EN
  logic [STATE_W-1:0] mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    inv_mix_column u_mix (
      .col_in  (work [STATE_W-1-COL_W*c -: COL_W]),
      .col_out (mixed[STATE_W-1-COL_W*c -: COL_W])
    );
  end
`else
  logic [1:0]       cnt;
  logic [COL_W-1:0] col_sel;
  logic [COL_W-1:0] col_mix;

  always_comb begin
    col_sel = '0;
    case (cnt)
      2'd0: col_sel = work[127:96];
      2'd1: col_sel = work[95:64];
      2'd2: col_sel = work[63:32];
      2'd3: col_sel = work[31:0];
      default: col_sel = '0;
    endcase
  end

  inv_mix_column u_mix (
    .col_in  (col_sel),
    .col_out (col_mix)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
`ifndef AES_INV_MIX_PARALLEL_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.state_in ^ bus.round_key;
            if (bus.skip_mix) begin
              state <= DONE;
            end else begin
              state <= BUSY;
`ifndef AES_INV_MIX_PARALLEL_EN
              cnt   <= '0;
`endif
            end
          end
        end
        BUSY: begin
`ifdef AES_INV_MIX_PARALLEL_EN
          work  <= mixed;
          state <= DONE;
`else
          case (cnt)
            2'd0: work[127:96] <= col_mix;
            2'd1: work[95:64]  <= col_mix;
            2'd2: work[63:32]  <= col_mix;
            default: work[31:0] <= col_mix;
          endcase
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
`endif
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
